// File: rtl/ball_pkt_pkg.sv
// Shared definitions for the 48-bit telemetry packet link: field geometry,
// receiver FSM encoding and a frame-to-field unpack helper.
package ball_pkt_pkg;

    localparam int unsigned PKT_W    = 48;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned TS_W     = 24;
    localparam int unsigned ID_W     = 8;
    localparam int unsigned CNT_W    = 16;

    localparam int unsigned DATA_LSB = 32;
    localparam int unsigned TS_LSB   = 8;
    localparam int unsigned ID_LSB   = 0;

    // Bit counter holds 0..PKT_W+1 so a long frame stays distinguishable
    localparam int unsigned BCNT_W   = $clog2(PKT_W + 2);

    localparam logic [ID_W-1:0] ACCEPT_ID = 8'h47;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
        logic [ID_W-1:0]   id;
    } pkt_t;

    // Split a received frame into its fields
    function automatic pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
        pkt_t p;
        p.data = raw[DATA_LSB +: DATA_W];
        p.ts   = raw[TS_LSB +: TS_W];
        p.id   = raw[ID_LSB +: ID_W];
        return p;
    endfunction

endpackage

// File: rtl/spi_packet_rx_if.sv
// SPI pins and decoded packet outputs of the telemetry receiver.
// id_reject exists only when PKT_ID_FILTER_EN is defined.
interface spi_packet_rx_if;
    import ball_pkt_pkg::*;

    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_ss_n;
    logic [DATA_W-1:0] pkt_data;
    logic [TS_W-1:0]   pkt_ts;
    logic [ID_W-1:0]   pkt_id;
    logic              pkt_valid;
    logic              frame_err;
    logic [CNT_W-1:0]  pkt_count;
`ifdef PKT_ID_FILTER_EN
    logic              id_reject;
`endif

    // Packet source side: drives SPI, observes results
    modport master (
        output spi_sclk,
        output spi_mosi,
        output spi_ss_n,
        input  pkt_data,
        input  pkt_ts,
        input  pkt_id,
        input  pkt_valid,
        input  frame_err,
`ifdef PKT_ID_FILTER_EN
        input  id_reject,
`endif
        input  pkt_count
    );

    // Receiver side
    modport slave (
        input  spi_sclk,
        input  spi_mosi,
        input  spi_ss_n,
        output pkt_data,
        output pkt_ts,
        output pkt_id,
        output pkt_valid,
        output frame_err,
`ifdef PKT_ID_FILTER_EN
        output id_reject,
`endif
        output pkt_count
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus rise/fall detect on
// the synchronized copy. Reset value 0 keeps a select that is already low
// at reset release from looking like a fresh frame start.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    logic [2:0] sync_q;

    // Two metastability stages plus one history stage for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_c  = sync_q[1] & ~sync_q[2];
    assign fall_c  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_packet_rx.sv
// SPI mode-0 slave receiver for the 48-bit telemetry packet
// {data[15:0], ts[23:0], id[7:0]}, MSB first. Flags short/long frames and
// counts good packets. Define PKT_ID_FILTER_EN to drop frames whose id is
// not ACCEPT_ID (reported on id_reject).
module spi_packet_rx
    import ball_pkt_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    spi_packet_rx_if.slave bus
);

    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall_unused;
    logic mosi_level;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic ss_level;
    logic ss_rise;
    logic ss_fall;

    spi_sync_edge u_sync_sclk (
        .clk     (clk),
        .reset   (reset),
        .d_i     (bus.spi_sclk),
        .level_o (sclk_level_unused),
        .rise_c  (sclk_rise),
        .fall_c  (sclk_fall_unused)
    );

    spi_sync_edge u_sync_mosi (
        .clk     (clk),
        .reset   (reset),
        .d_i     (bus.spi_mosi),
        .level_o (mosi_level),
        .rise_c  (mosi_rise_unused),
        .fall_c  (mosi_fall_unused)
    );

    spi_sync_edge u_sync_ss (
        .clk     (clk),
        .reset   (reset),
        .d_i     (bus.spi_ss_n),
        .level_o (ss_level),
        .rise_c  (ss_rise),
        .fall_c  (ss_fall)
    );

    rx_state_e         state_q;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic [PKT_W-1:0]  shift_q;
    pkt_t              pkt_q;
    logic              valid_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
`ifdef PKT_ID_FILTER_EN
    logic              rej_q;
`endif

    // Frame FSM: deserialize, judge length (and id) in DONE, publish result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_HI;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pkt_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef PKT_ID_FILTER_EN
            rej_q     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef PKT_ID_FILTER_EN
            rej_q   <= 1'b0;
`endif
            case (state_q)
                WAIT_HI: begin
                    if (ss_level) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (ss_fall) begin
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Deselect takes priority over a coincident sclk rise
                    if (ss_rise) begin
                        state_q <= DONE;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[PKT_W-2:0], mosi_level};
                        if (bit_cnt_q != BCNT_W'(PKT_W + 1)) begin
                            bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (bit_cnt_q == BCNT_W'(PKT_W)) begin
`ifdef PKT_ID_FILTER_EN
                        if (shift_q[ID_LSB +: ID_W] != ACCEPT_ID) begin
                            rej_q <= 1'b1;
                        end else begin
                            pkt_q   <= unpack_pkt(shift_q);
                            valid_q <= 1'b1;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
`else
                        pkt_q   <= unpack_pkt(shift_q);
                        valid_q <= 1'b1;
                        cnt_q   <= cnt_q + CNT_W'(1);
`endif
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= WAIT_HI;
            endcase
        end
    end

    assign bus.pkt_data  = pkt_q.data;
    assign bus.pkt_ts    = pkt_q.ts;
    assign bus.pkt_id    = pkt_q.id;
    assign bus.pkt_valid = valid_q;
    assign bus.frame_err = err_q;
    assign bus.pkt_count = cnt_q;
`ifdef PKT_ID_FILTER_EN
    assign bus.id_reject = rej_q;
`endif

endmodule

// File: tb/tb_spi_packet_rx.sv
// Randomized bench for spi_packet_rx with a frame-level reference model.
// Honors PKT_ID_FILTER_EN the same way as the design.
module tb_spi_packet_rx;
    import ball_pkt_pkg::*;

    localparam int HALF = 4;   // sclk = clk/8
    localparam int GAP  = 16;  // two sclk periods of deselect

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_packet_rx_if bus ();

    spi_packet_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: last good packet and good-packet count
    logic [DATA_W-1:0] m_data;
    logic [TS_W-1:0]   m_ts;
    logic [ID_W-1:0]   m_id;
    logic [CNT_W-1:0]  m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_data = '0;
        m_ts   = '0;
        m_id   = '0;
        m_cnt  = '0;
    endtask

    task automatic start_frame();
        bus.spi_ss_n = 1'b0;
        clk_wait(HALF);
    endtask

    // Shift the low nbits of val, MSB first, mode 0
    task automatic shift_bits(input int nbits, input logic [63:0] val);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.spi_mosi = val[i];
            clk_wait(HALF);
            bus.spi_sclk = 1'b1;
            clk_wait(HALF);
            bus.spi_sclk = 1'b0;
        end
    endtask

    // Deselect, watch the response window and compare with the model.
    // aborted: frame was cut by reset, so nothing may be reported.
    // coincide: one extra sclk rise lands on the same clk as the deselect.
    task automatic end_frame(input string tag, input int nbits, input logic [63:0] val,
                             input bit aborted, input bit coincide);
        int nv = 0, ne = 0, nr = 0, both = 0, lat = 0;
        bit exp_v = 0, exp_e = 0, exp_r = 0;
        logic [ID_W-1:0] id;

        clk_wait(HALF);
        if (coincide) begin
            bus.spi_mosi = 1'b1;
            bus.spi_sclk = 1'b1;
        end
        bus.spi_ss_n = 1'b1;
        for (int c = 1; c <= GAP; c++) begin
            @(negedge clk);
            if (bus.pkt_valid) begin
                nv++;
                lat = c;
            end
            if (bus.frame_err) ne++;
            if (bus.pkt_valid && bus.frame_err) both++;
`ifdef PKT_ID_FILTER_EN
            if (bus.id_reject) nr++;
`endif
            if (c == HALF && coincide) bus.spi_sclk = 1'b0;
        end

        if (!aborted) begin
            if (nbits == int'(PKT_W)) begin
                id = ID_W'(val & 64'hFF);
`ifdef PKT_ID_FILTER_EN
                exp_r = (id != ACCEPT_ID);
`endif
                if (!exp_r) begin
                    exp_v  = 1;
                    m_data = DATA_W'((val >> 32) & 64'hFFFF);
                    m_ts   = TS_W'((val >> 8) & 64'hFF_FFFF);
                    m_id   = id;
                    m_cnt  = m_cnt + CNT_W'(1);
                end
            end else begin
                exp_e = 1;
            end
        end

        check({tag, ".valid_pulses"}, 64'(nv), 64'(exp_v));
        check({tag, ".err_pulses"}, 64'(ne), 64'(exp_e));
        check({tag, ".reject_pulses"}, 64'(nr), 64'(exp_r));
        check({tag, ".valid_and_err"}, 64'(both), 64'd0);
        if (exp_v) check({tag, ".latency"}, 64'(lat), 64'd4);
        check({tag, ".data"}, 64'(bus.pkt_data), 64'(m_data));
        check({tag, ".ts"}, 64'(bus.pkt_ts), 64'(m_ts));
        check({tag, ".id"}, 64'(bus.pkt_id), 64'(m_id));
        check({tag, ".count"}, 64'(bus.pkt_count), 64'(m_cnt));
    endtask

    task automatic frame(input string tag, input int nbits, input logic [63:0] val);
        start_frame();
        shift_bits(nbits, val);
        end_frame(tag, nbits, val, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, ".valid"}, 64'(bus.pkt_valid), 64'd0);
        check({tag, ".err"}, 64'(bus.frame_err), 64'd0);
        check({tag, ".data"}, 64'(bus.pkt_data), 64'd0);
        check({tag, ".ts"}, 64'(bus.pkt_ts), 64'd0);
        check({tag, ".id"}, 64'(bus.pkt_id), 64'd0);
        check({tag, ".count"}, 64'(bus.pkt_count), 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        int len;

        reset        = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_ss_n = 1'b1;
        model_reset();
        clk_wait(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        clk_wait(6);

        frame("good_ref", 48, 64'h0000_0027_0B3C_5B47);

        frame("short47", 47, rand64());
        frame("long49", 49, rand64());
        frame("good_after_err", 48, rand64() & 64'hFFFF_FFFF_FFFF_FF00 | 64'h47);

        // Randomized lengths and ids
        for (int k = 0; k < 8; k++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 48;
            v   = rand64();
            if ($urandom_range(0, 1) == 1) v = (v & ~64'hFF) | 64'h47;
            frame($sformatf("rand%0d", k), len, v);
        end

        // Reset mid-frame, release with select still low
        v = rand64();
        start_frame();
        shift_bits(20, v >> 28);
        reset = 1'b1;
        clk_wait(2);
        model_reset();
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        shift_bits(28, v);
        end_frame("aborted", 48, v, 1'b1, 1'b0);
        frame("good_after_reset", 48, 64'h0000_1234_5678_9A47);

        // Back-to-back frames separated by two sclk periods
        frame("b2b_a", 48, 64'h0000_AAAA_0101_0147);
        frame("b2b_b", 48, 64'h0000_5555_FEFE_FE47);

        // sclk rise coincident with deselect is not counted
        v = 64'h0000_C0DE_0F0F_0F47;
        start_frame();
        shift_bits(48, v);
        end_frame("coincident", 48, v, 1'b0, 1'b1);

        // Counter wrap
        force dut.cnt_q = 16'hFFFF;
        clk_wait(1);
        release dut.cnt_q;
        m_cnt = 16'hFFFF;
        clk_wait(1);
        check("preset.count", 64'(bus.pkt_count), 64'hFFFF);
        frame("wrap", 48, 64'h0000_0001_0002_0347);

        // Id filter cases (accepted in both without the filter)
        frame("id48", 48, 64'h0000_0027_0B3C_5B48);
        frame("id47", 48, 64'h0000_0027_0B3C_5B47);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
